// File: rtl/execute_pipe.sv
// Execute stage: ALU, address generation, branch evaluation and an optional iterative
// multiplier (enabled by defining EXECUTE_PIPE_MUL_EN), with a registered valid/ready output.
module execute_pipe #(
   parameter int REG_WIDTH      = 16,
   parameter int REG_IDX_WIDTH  = 4,
   parameter int MUL_RADIX_BITS = 2
) (
   input  logic                     I_CLOCK,
   input  logic                     I_RESET_N,
   input  logic                     I_Flush,
   input  logic                     I_Valid,
   output logic                     O_Ready,
   input  logic [3:0]               I_AluOp,
   input  logic                     I_UseImm,
   input  logic [REG_WIDTH-1:0]     I_Src1Value,
   input  logic [REG_WIDTH-1:0]     I_Src2Value,
   input  logic [REG_WIDTH-1:0]     I_Imm,
   input  logic [REG_IDX_WIDTH-1:0] I_DestRegIdx,
   input  logic [2:0]               I_BrCond,
   output logic                     O_Valid,
   input  logic                     I_Ready,
   output logic [REG_WIDTH-1:0]     O_ALUOut,
   output logic [REG_IDX_WIDTH-1:0] O_DestRegIdx,
   output logic                     O_BrTaken,
   output logic                     O_Illegal,
   output logic                     O_Busy
);

   localparam int SHW = $clog2(REG_WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MOV  = 4'd5;
   localparam logic [3:0] OP_MOVI = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_ADDR = 4'd9;
   localparam logic [3:0] OP_BR   = 4'd10;

   if (REG_WIDTH % MUL_RADIX_BITS != 0) begin : g_bad_radix
      $error("MUL_RADIX_BITS must divide REG_WIDTH");
   end

   logic [REG_WIDTH-1:0] opb;
   logic [REG_WIDTH-1:0] alu_res;
   logic                 alu_taken;
   logic                 alu_illegal;
   logic                 br_n, br_z, br_p;
   logic [SHW-1:0]       shamt;
   logic                 accept;
   logic                 drain;

   always_comb begin
      opb         = I_UseImm ? I_Imm : I_Src2Value;
      shamt       = opb[SHW-1:0];
      br_n        = I_Src1Value[REG_WIDTH-1];
      br_z        = (I_Src1Value == '0);
      br_p        = !br_n && !br_z;
      alu_res     = '0;
      alu_taken   = 1'b0;
      alu_illegal = 1'b0;
      case (I_AluOp)
         OP_ADD:  alu_res = I_Src1Value + opb;
         OP_SUB:  alu_res = I_Src1Value - opb;
         OP_AND:  alu_res = I_Src1Value & opb;
         OP_OR:   alu_res = I_Src1Value | opb;
         OP_XOR:  alu_res = I_Src1Value ^ opb;
         OP_MOV:  alu_res = I_Src1Value;
         OP_MOVI: alu_res = opb;
         OP_SHL:  alu_res = I_Src1Value << shamt;
         OP_SRA:  alu_res = REG_WIDTH'($signed(I_Src1Value) >>> shamt);
         OP_ADDR: alu_res = I_Src1Value + opb;
         // Branch target is always computed from the base PC, taken or not.
         OP_BR: begin
            alu_res   = I_Src2Value + I_Imm;
            alu_taken = |(I_BrCond & {br_n, br_z, br_p});
         end
`ifdef EXECUTE_PIPE_MUL_EN
         4'd11:   alu_res = '0;
`endif
         default: alu_illegal = 1'b1;
      endcase
   end

   // Handshake: an op enters when I_Valid && O_Ready, a result leaves when
   // O_Valid && I_Ready; outputs are held stable while O_Valid && !I_Ready.
   assign accept = I_Valid && O_Ready;
   assign drain  = O_Valid && I_Ready;

`ifdef EXECUTE_PIPE_MUL_EN
   localparam int STEPS = REG_WIDTH / MUL_RADIX_BITS;
   localparam int CNT_W = $clog2(STEPS + 1);

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q;
   logic [REG_WIDTH-1:0]      acc_q, mcand_q, mplier_q, partial;
   logic [REG_IDX_WIDTH-1:0]  mul_dest_q;
   logic [MUL_RADIX_BITS-1:0] digit;
   logic                      is_mul;

   assign is_mul  = (I_AluOp == 4'd11);
   assign O_Busy  = (state_q == S_MUL);
   assign O_Ready = (state_q == S_IDLE) && (!O_Valid || I_Ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!I_Flush && accept && is_mul) state_d = S_MUL;
         S_MUL:   if (I_Flush || cnt_q == CNT_W'(1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Shift-and-add over MUL_RADIX_BITS multiplier bits, LSB first.
   always_comb begin
      digit   = mplier_q[MUL_RADIX_BITS-1:0];
      partial = '0;
      for (int i = 0; i < MUL_RADIX_BITS; i++) begin
         if (digit[i]) partial = partial + (mcand_q << i);
      end
   end

   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) state_q <= S_IDLE;
      else            state_q <= state_d;
   end
`else
   assign O_Busy  = 1'b0;
   assign O_Ready = !O_Valid || I_Ready;
`endif

   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         O_Valid      <= 1'b0;
         O_ALUOut     <= '0;
         O_DestRegIdx <= '0;
         O_BrTaken    <= 1'b0;
         O_Illegal    <= 1'b0;
`ifdef EXECUTE_PIPE_MUL_EN
         cnt_q        <= '0;
         acc_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         mul_dest_q   <= '0;
`endif
      end else if (I_Flush) begin
         O_Valid <= 1'b0;
`ifdef EXECUTE_PIPE_MUL_EN
         cnt_q   <= '0;
`endif
      end else if (accept) begin
`ifdef EXECUTE_PIPE_MUL_EN
         if (is_mul) begin
            O_Valid    <= 1'b0;
            cnt_q      <= CNT_W'(STEPS);
            acc_q      <= '0;
            mcand_q    <= I_Src1Value;
            mplier_q   <= opb;
            mul_dest_q <= I_DestRegIdx;
         end else
`endif
         begin
            O_Valid      <= 1'b1;
            O_ALUOut     <= alu_res;
            O_DestRegIdx <= I_DestRegIdx;
            O_BrTaken    <= alu_taken;
            O_Illegal    <= alu_illegal;
         end
      end
`ifdef EXECUTE_PIPE_MUL_EN
      else if (state_q == S_MUL) begin
         cnt_q    <= cnt_q - CNT_W'(1);
         acc_q    <= acc_q + partial;
         mcand_q  <= mcand_q << MUL_RADIX_BITS;
         mplier_q <= mplier_q >> MUL_RADIX_BITS;
         if (cnt_q == CNT_W'(1)) begin
            O_Valid      <= 1'b1;
            O_ALUOut     <= acc_q + partial;
            O_DestRegIdx <= mul_dest_q;
            O_BrTaken    <= 1'b0;
            O_Illegal    <= 1'b0;
         end
      end
`endif
      else if (drain) begin
         O_Valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_pipe.sv
// Randomized scoreboard bench for execute_pipe; the reference model follows the
// EXECUTE_PIPE_MUL_EN define so it matches whichever build is compiled.
module tb_execute_pipe;

   localparam int W     = 16;
   localparam int IW    = 4;
   localparam int R     = 2;
   localparam int STEPS = W / R;

   logic          I_CLOCK = 1'b0;
   logic          I_RESET_N = 1'b1;
   logic          I_Flush = 1'b0;
   logic          I_Valid = 1'b0;
   logic          O_Ready;
   logic [3:0]    I_AluOp = '0;
   logic          I_UseImm = 1'b0;
   logic [W-1:0]  I_Src1Value = '0;
   logic [W-1:0]  I_Src2Value = '0;
   logic [W-1:0]  I_Imm = '0;
   logic [IW-1:0] I_DestRegIdx = '0;
   logic [2:0]    I_BrCond = '0;
   logic          O_Valid;
   logic          I_Ready = 1'b1;
   logic [W-1:0]  O_ALUOut;
   logic [IW-1:0] O_DestRegIdx;
   logic          O_BrTaken;
   logic          O_Illegal;
   logic          O_Busy;

   execute_pipe #(.REG_WIDTH(W), .REG_IDX_WIDTH(IW), .MUL_RADIX_BITS(R)) dut (
      .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_Flush(I_Flush),
      .I_Valid(I_Valid), .O_Ready(O_Ready), .I_AluOp(I_AluOp),
      .I_UseImm(I_UseImm), .I_Src1Value(I_Src1Value), .I_Src2Value(I_Src2Value),
      .I_Imm(I_Imm), .I_DestRegIdx(I_DestRegIdx), .I_BrCond(I_BrCond),
      .O_Valid(O_Valid), .I_Ready(I_Ready), .O_ALUOut(O_ALUOut),
      .O_DestRegIdx(O_DestRegIdx), .O_BrTaken(O_BrTaken), .O_Illegal(O_Illegal),
      .O_Busy(O_Busy)
   );

   typedef struct {
      logic [W-1:0]  out;
      logic [IW-1:0] dest;
      logic          taken;
      logic          illegal;
      logic          is_mul;
      int            due;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   bit   in_reset = 1'b1;
   int   ready_mode = 0;

   // ---------------- clock / cycle count (state changes on falling edge)
   initial forever #5 I_CLOCK = ~I_CLOCK;
   always @(negedge I_CLOCK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic fail_note(input string name);
      n_checks++;
      $display("FAIL %s: got no event expected event within budget (cycle %0d)", name, cyc);
   endtask

   // ---------------- reference model: what the op should produce and when
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, src2, imm,
                                  input logic use_imm, input logic [IW-1:0] dest,
                                  input logic [2:0] cond, input int c);
      exp_t         e;
      logic [W-1:0] b;
      int           sh, sa;
      logic         n, z, p;
      b = use_imm ? imm : src2;
      sh = int'(b) % W;
      sa = int'($signed(a));
      e.out = '0; e.dest = dest; e.taken = 1'b0; e.illegal = 1'b0;
      e.is_mul = 1'b0; e.due = c + 1;
      case (op)
         4'd0:  e.out = a + b;
         4'd1:  e.out = a - b;
         4'd2:  e.out = a & b;
         4'd3:  e.out = a | b;
         4'd4:  e.out = a ^ b;
         4'd5:  e.out = a;
         4'd6:  e.out = b;
         4'd7:  e.out = a << sh;
         4'd8:  e.out = W'(sa >>> sh);
         4'd9:  e.out = a + b;
         4'd10: begin
            n = a[W-1]; z = (a == 0); p = !n && !z;
            e.taken = (cond[2] && n) || (cond[1] && z) || (cond[0] && p);
            e.out = src2 + imm;
         end
`ifdef EXECUTE_PIPE_MUL_EN
         4'd11: begin
            e.out = W'(int'(a) * int'(b));
            e.is_mul = 1'b1;
            e.due = c + 1 + STEPS;
         end
`endif
         default: e.illegal = 1'b1;
      endcase
      return e;
   endfunction

   // ---------------- driver tasks (drive 1 time unit after the rising edge)
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, src2, imm,
                        input logic use_imm, input logic [IW-1:0] dest,
                        input logic [2:0] cond, output int tries);
      bit done = 1'b0;
      tries = 0;
      while (tries < 40 && !done) begin
         @(posedge I_CLOCK); #1;
         I_Flush = 1'b0; I_Valid = 1'b1; I_AluOp = op; I_Src1Value = a;
         I_Src2Value = src2; I_Imm = imm; I_UseImm = use_imm;
         I_DestRegIdx = dest; I_BrCond = cond;
         tries++;
         #3;
         if (O_Ready) begin
            exp_q.push_back(model(op, a, src2, imm, use_imm, dest, cond, cyc));
            done = 1'b1;
         end
      end
      if (!done) fail_note("accept_timeout");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge I_CLOCK); #1;
         I_Valid = 1'b0; I_Flush = 1'b0;
      end
   endtask

   task automatic flush_now();
      @(posedge I_CLOCK); #1;
      I_Flush = 1'b1; I_Valid = 1'b1;
      I_AluOp = 4'($urandom_range(0, 15));
      I_Src1Value = W'($urandom);
      #3;
      exp_q.delete();
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'h7FFF;
         2:       return 16'h8000;
         3:       return 16'hFFFF;
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- downstream sink
   initial forever begin
      @(posedge I_CLOCK); #1;
      case (ready_mode)
         0:       I_Ready = 1'b1;
         1:       I_Ready = ($urandom_range(0, 3) != 0);
         default: I_Ready = 1'b0;
      endcase
   end

   // ---------------- scoreboard monitor
   initial begin
      bit ev, eb;
      forever begin
         @(posedge I_CLOCK); #3;
         if (!in_reset) begin
            ev = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            eb = 1'b0;
            foreach (exp_q[i]) if (exp_q[i].is_mul && cyc < exp_q[i].due) eb = 1'b1;
            check("o_valid", 32'(O_Valid), 32'(ev));
            check("o_busy", 32'(O_Busy), 32'(eb));
            check("o_ready", 32'(O_Ready), 32'(!eb && (!ev || I_Ready)));
            if (ev) begin
               check("result", 32'({O_ALUOut, O_DestRegIdx, O_BrTaken, O_Illegal}),
                     32'({exp_q[0].out, exp_q[0].dest, exp_q[0].taken, exp_q[0].illegal}));
               if (I_Ready && !I_Flush) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- main sequence and final report
   initial begin
      int tries;
      #2 I_RESET_N = 1'b0;
      #1 check("reset_outs", 32'({O_Valid, O_ALUOut, O_DestRegIdx, O_BrTaken, O_Illegal, O_Busy}), 32'd0);
      check("reset_ready", 32'(O_Ready), 32'd1);
      repeat (2) @(posedge I_CLOCK);
      #1 I_RESET_N = 1'b1;
      in_reset = 1'b0;

      // directed corner cases
      ready_mode = 0;
      issue(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 4'd3, 3'b000, tries);
      issue(4'd10, 16'h0000, 16'h0100, 16'hFFFE, 1'b0, 4'd5, 3'b010, tries);
      issue(4'd10, 16'h0000, 16'h0100, 16'hFFFE, 1'b0, 4'd6, 3'b101, tries);
      issue(4'd10, 16'h8000, 16'h0200, 16'h0004, 1'b1, 4'd7, 3'b100, tries);
      issue(4'd1, 16'h0000, 16'h0001, 16'h0000, 1'b0, 4'd1, 3'b000, tries);
      issue(4'd8, 16'h8000, 16'h0000, 16'h000F, 1'b1, 4'd2, 3'b000, tries);
      issue(4'd7, 16'h0001, 16'h0013, 16'h0000, 1'b0, 4'd4, 3'b000, tries);
      issue(4'd6, 16'h1234, 16'h0000, 16'hBEEF, 1'b1, 4'd8, 3'b000, tries);
      issue(4'd13, 16'h1111, 16'h2222, 16'h0000, 1'b0, 4'd9, 3'b000, tries);
      issue(4'd11, 16'h0012, 16'h0034, 16'h0000, 1'b0, 4'd10, 3'b000, tries);
      issue(4'd9, 16'hFFF0, 16'h0000, 16'h0020, 1'b1, 4'd11, 3'b000, tries);
      idle(STEPS + 2);

      // stall for 3 edges, then the next op must go in on the edge I_Ready rises
      ready_mode = 2;
      issue(4'd4, 16'hA5A5, 16'h0FF0, 16'h0000, 1'b0, 4'd12, 3'b000, tries);
      idle(3);
      ready_mode = 0;
      issue(4'd3, 16'h00F0, 16'h0F00, 16'h0000, 1'b0, 4'd13, 3'b000, tries);
      check("accept_on_ready_rise", 32'(tries), 32'd1);
      idle(2);

      // flush in the middle of a multiply
      issue(4'd11, 16'h0123, 16'h0045, 16'h0000, 1'b0, 4'd14, 3'b000, tries);
      idle(3);
      flush_now();
      idle(3);

      // randomized traffic with back-pressure and occasional flushes
      for (int k = 0; k < 300; k++) begin
         int r;
         if (k % 40 == 0) ready_mode = $urandom_range(0, 1);
         r = $urandom_range(0, 29);
         if (r == 0) flush_now();
         else if (r < 4) idle(1);
         else issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), pick_operand(),
                    1'($urandom_range(0, 1)), IW'($urandom), 3'($urandom_range(0, 7)), tries);
      end
      ready_mode = 0;
      idle(STEPS + 3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      // asynchronous reset in the middle of a multiply
      issue(4'd11, 16'h0012, 16'h0034, 16'h0000, 1'b0, 4'd15, 3'b000, tries);
      idle(2);
      @(posedge I_CLOCK); #2;
      in_reset = 1'b1;
      I_RESET_N = 1'b0;
      #1 check("midmul_reset_outs", 32'({O_Valid, O_ALUOut, O_DestRegIdx, O_BrTaken, O_Illegal, O_Busy}), 32'd0);
      check("midmul_reset_ready", 32'(O_Ready), 32'd1);
      exp_q.delete();
      I_Valid = 1'b0;
      repeat (2) @(posedge I_CLOCK);
      #1 I_RESET_N = 1'b1;
      in_reset = 1'b0;
      idle(STEPS + 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
